// File: rtl/ysyx_25040111_ifu.sv
// Instruction fetch unit: holds the PC, fetches one word per PC over AXI4-Lite
// and hands {inst, pc} to decode, then waits for commit to return the next PC.
module ysyx_25040111_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        pc_upd_valid,
    input  logic [31:0] pc_upd,
    output logic        fetch_err,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_ADDR,
        S_DATA,
        S_HOLD,
        S_WAIT,
        S_ERR
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc;
    logic        ar_req;

    assign araddr  = pc;
    assign arvalid = ar_req;

    // NOTE: state and datapath registers use non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_ADDR;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            S_ADDR: begin
                if (!ar_req && pc[1:0] != 2'b00) begin
                    state_next = S_ERR;
                end else if (ar_req && arready) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (rvalid) begin
                    state_next = (rresp == 2'b00) ? S_HOLD : S_ERR;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pc_upd_valid) begin
                    state_next = S_ADDR;
                end
            end
            S_ERR:   state_next = S_ERR;
            default: state_next = S_ERR;
        endcase
    end

    always_comb begin
        rready     = 1'b0;
        inst_valid = 1'b0;
        fetch_err  = 1'b0;
        unique case (state)
            S_DATA:  rready     = 1'b1;
            S_HOLD:  inst_valid = 1'b1;
            S_ERR:   fetch_err  = 1'b1;
            default: ;
        endcase
    end

    // The request flag is raised on the edge that enters ADDR so a redirect
    // reaches the bus one cycle after pc_upd_valid; after reset it rises one
    // cycle later, once the reset PC has been checked for alignment.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc        <= RESET_PC;
            ar_req    <= 1'b0;
            inst      <= 32'h0;
            inst_pc   <= 32'h0;
            fetch_cnt <= 32'h0;
        end else begin
            unique case (state)
                S_ADDR: begin
                    if (!ar_req && pc[1:0] == 2'b00) begin
                        ar_req <= 1'b1;
                    end else if (ar_req && arready) begin
                        ar_req <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (rvalid && rresp == 2'b00) begin
                        inst    <= rdata;
                        inst_pc <= pc;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        fetch_cnt <= fetch_cnt + 32'd1;
                    end
                end
                S_WAIT: begin
                    if (pc_upd_valid) begin
                        pc     <= pc_upd;
                        ar_req <= (pc_upd[1:0] == 2'b00);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_ifu.sv
// Directed bench for the fetch unit: inputs change and outputs are sampled on
// the falling edge, so each sample shows the state left by the previous rising edge.
module tb_ysyx_25040111_ifu;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        pc_upd_valid;
    logic [31:0] pc_upd;
    logic        fetch_err;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;
    int ar_hs  = 0;

    always #5 clock = ~clock;

    ysyx_25040111_ifu dut (
        .clock        (clock),
        .reset        (reset),
        .araddr       (araddr),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rvalid       (rvalid),
        .rready       (rready),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .pc_upd_valid (pc_upd_valid),
        .pc_upd       (pc_upd),
        .fetch_err    (fetch_err),
        .fetch_cnt    (fetch_cnt)
    );

    always @(posedge clock) begin
        if (!reset && arvalid && arready) ar_hs++;
    end

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic clear_inputs;
        arready      = 1'b0;
        rdata        = 32'h0;
        rresp        = 2'b00;
        rvalid       = 1'b0;
        inst_ready   = 1'b0;
        pc_upd_valid = 1'b0;
        pc_upd       = 32'h0;
    endtask

    // Applies reset for two edges, then releases it and steps to the first
    // post-reset cycle.
    task automatic apply_reset;
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Full fetch with arready=1 and rvalid one cycle after AR; leaves the DUT in WAIT.
    task automatic fetch_one(input logic [31:0] word, input logic [31:0] exp_pc);
        int n;
        n = 0;
        while (!arvalid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (arvalid !== 1'b1) begin
            $display("FAIL fetch_one_arvalid_timeout: arvalid=%b required 1", arvalid);
            errors++;
        end
        checks++;
        if (araddr !== exp_pc) begin
            $display("FAIL fetch_one_araddr: got %h required %h", araddr, exp_pc);
            errors++;
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = word;
        rresp   = 2'b00;
        tick();
        rvalid = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst !== word || inst_pc !== exp_pc) begin
            $display("FAIL fetch_one_inst: valid=%b inst=%h pc=%h required 1 %h %h",
                     inst_valid, inst, inst_pc, word, exp_pc);
            errors++;
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (arvalid !== 1'b0 || rready !== 1'b0 || inst_valid !== 1'b0) begin
            $display("FAIL reset_handshake: arvalid=%b rready=%b inst_valid=%b required 0 0 0",
                     arvalid, rready, inst_valid);
            errors++;
        end
        checks++;
        if (inst !== 32'h0 || inst_pc !== 32'h0) begin
            $display("FAIL reset_inst: inst=%h inst_pc=%h required 0 0", inst, inst_pc);
            errors++;
        end
        checks++;
        if (fetch_err !== 1'b0 || fetch_cnt !== 32'h0 || araddr !== 32'h8000_0000) begin
            $display("FAIL reset_misc: err=%b cnt=%0d araddr=%h required 0 0 80000000",
                     fetch_err, fetch_cnt, araddr);
            errors++;
        end
        reset = 1'b0;
        tick();
    endtask

    // Plan 1: called right after reset release.
    task automatic test_basic_fetch;
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h8000_0000) begin
            $display("FAIL basic_first_ar: arvalid=%b araddr=%h required 1 80000000", arvalid, araddr);
            errors++;
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        checks++;
        if (arvalid !== 1'b0 || rready !== 1'b1 || inst_valid !== 1'b0) begin
            $display("FAIL basic_data_phase: arvalid=%b rready=%b inst_valid=%b required 0 1 0",
                     arvalid, rready, inst_valid);
            errors++;
        end
        rvalid = 1'b1;
        rdata  = 32'h0000_0513;
        tick();
        rvalid = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h0000_0513 || inst_pc !== 32'h8000_0000) begin
            $display("FAIL basic_inst: valid=%b inst=%h pc=%h required 1 00000513 80000000",
                     inst_valid, inst, inst_pc);
            errors++;
        end
        checks++;
        if (rready !== 1'b0) begin
            $display("FAIL basic_rready_low: rready=%b required 0", rready);
            errors++;
        end
    endtask

    // Plan 3: continues from HOLD.
    task automatic test_hold_backpressure;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst !== 32'h0000_0513 ||
                inst_pc !== 32'h8000_0000 || fetch_cnt !== 32'd0) begin
                $display("FAIL hold_stable_%0d: valid=%b inst=%h pc=%h cnt=%0d required 1 00000513 80000000 0",
                         i, inst_valid, inst, inst_pc, fetch_cnt);
                errors++;
            end
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++;
        if (fetch_cnt !== 32'd1 || inst_valid !== 1'b0) begin
            $display("FAIL hold_handoff: cnt=%0d inst_valid=%b required 1 0", fetch_cnt, inst_valid);
            errors++;
        end
    endtask

    // Plan 4: continues from WAIT.
    task automatic test_pc_update;
        tick();
        checks++;
        if (arvalid !== 1'b0) begin
            $display("FAIL wait_no_ar: arvalid=%b required 0", arvalid);
            errors++;
        end
        pc_upd_valid = 1'b1;
        pc_upd       = 32'h8000_0010;
        tick();
        pc_upd_valid = 1'b0;
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h8000_0010) begin
            $display("FAIL redirect_ar: arvalid=%b araddr=%h required 1 80000010", arvalid, araddr);
            errors++;
        end
        arready = 1'b1;
        tick();
        arready      = 1'b0;
        pc_upd_valid = 1'b1;
        pc_upd       = 32'h8000_0100;
        tick();
        tick();
        pc_upd_valid = 1'b0;
        checks++;
        if (rready !== 1'b1 || araddr !== 32'h8000_0010) begin
            $display("FAIL data_pc_upd_ignored: rready=%b araddr=%h required 1 80000010", rready, araddr);
            errors++;
        end
        rvalid = 1'b1;
        rdata  = 32'h0010_0093;
        tick();
        rvalid = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h8000_0010) begin
            $display("FAIL redirect_inst: valid=%b inst=%h pc=%h required 1 00100093 80000010",
                     inst_valid, inst, inst_pc);
            errors++;
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++;
        if (fetch_cnt !== 32'd2) begin
            $display("FAIL redirect_cnt: cnt=%0d required 2", fetch_cnt);
            errors++;
        end
    endtask

    // Plan 2: called right after reset release; leaves the DUT in DATA.
    task automatic test_ar_stall;
        int hs0;
        hs0 = ar_hs;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (arvalid !== 1'b1 || araddr !== 32'h8000_0000) begin
                $display("FAIL stall_hold_%0d: arvalid=%b araddr=%h required 1 80000000", i, arvalid, araddr);
                errors++;
            end
            tick();
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        tick();
        checks++;
        if (ar_hs - hs0 !== 1 || arvalid !== 1'b0 || rready !== 1'b1) begin
            $display("FAIL stall_one_hs: handshakes=%0d arvalid=%b rready=%b required 1 0 1",
                     ar_hs - hs0, arvalid, rready);
            errors++;
        end
    endtask

    // Plan 5a: continues from DATA.
    task automatic test_rresp_err;
        int hs0;
        hs0    = ar_hs;
        rvalid = 1'b1;
        rresp  = 2'b10;
        rdata  = 32'hdead_beef;
        tick();
        rvalid = 1'b0;
        rresp  = 2'b00;
        checks++;
        if (fetch_err !== 1'b1 || inst_valid !== 1'b0 || rready !== 1'b0) begin
            $display("FAIL rresp_err: err=%b inst_valid=%b rready=%b required 1 0 0",
                     fetch_err, inst_valid, rready);
            errors++;
        end
        pc_upd_valid = 1'b1;
        pc_upd       = 32'h8000_0004;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (arvalid !== 1'b0 || inst_valid !== 1'b0 || fetch_err !== 1'b1 || inst !== 32'h0) begin
                $display("FAIL rresp_terminal_%0d: arvalid=%b inst_valid=%b err=%b inst=%h required 0 0 1 0",
                         i, arvalid, inst_valid, fetch_err, inst);
                errors++;
            end
        end
        pc_upd_valid = 1'b0;
        checks++;
        if (ar_hs !== hs0) begin
            $display("FAIL rresp_no_ar: handshakes=%0d required %0d", ar_hs, hs0);
            errors++;
        end
    endtask

    // Plan 5b: called right after reset release.
    task automatic test_misaligned;
        int hs0;
        fetch_one(32'h0000_0013, 32'h8000_0000);
        hs0          = ar_hs;
        arready      = 1'b1;
        pc_upd_valid = 1'b1;
        pc_upd       = 32'h8000_0002;
        tick();
        pc_upd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (arvalid !== 1'b0) begin
                $display("FAIL misaligned_no_ar_%0d: arvalid=%b required 0", i, arvalid);
                errors++;
            end
            tick();
        end
        arready = 1'b0;
        checks++;
        if (fetch_err !== 1'b1 || ar_hs !== hs0 || inst_valid !== 1'b0) begin
            $display("FAIL misaligned_err: err=%b handshakes=%0d inst_valid=%b required 1 %0d 0",
                     fetch_err, ar_hs - hs0, inst_valid, 0);
            errors++;
        end
    endtask

    // Plan 6: called right after reset release.
    task automatic test_reset_mid_data;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        checks++;
        if (rready !== 1'b1) begin
            $display("FAIL mid_reset_in_data: rready=%b required 1", rready);
            errors++;
        end
        reset = 1'b1;
        tick();
        checks++;
        if (arvalid !== 1'b0 || rready !== 1'b0 || inst_valid !== 1'b0 || fetch_err !== 1'b0 ||
            fetch_cnt !== 32'h0 || inst !== 32'h0 || inst_pc !== 32'h0 || araddr !== 32'h8000_0000) begin
            $display("FAIL mid_reset_values: arv=%b rr=%b iv=%b err=%b cnt=%0d inst=%h ipc=%h araddr=%h required all zero, araddr 80000000",
                     arvalid, rready, inst_valid, fetch_err, fetch_cnt, inst, inst_pc, araddr);
            errors++;
        end
        reset = 1'b0;
        tick();
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h8000_0000) begin
            $display("FAIL mid_reset_restart: arvalid=%b araddr=%h required 1 80000000", arvalid, araddr);
            errors++;
        end
        fetch_one(32'h0000_0297, 32'h8000_0000);
        checks++;
        if (fetch_cnt !== 32'd1 || fetch_err !== 1'b0) begin
            $display("FAIL mid_reset_refetch: cnt=%0d err=%b required 1 0", fetch_cnt, fetch_err);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_hold_backpressure();
        test_pc_update();
        apply_reset();
        test_ar_stall();
        test_rresp_err();
        apply_reset();
        test_misaligned();
        apply_reset();
        test_reset_mid_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
